reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Receiving end of the system reset-request interface. Collects reset requests from the power-on reset, the watchdog, an external reset button and a software reset strobe. Produces two staggered, stretched reset outputs: peripherals are released first, the CPU afterwards. Keeps a sticky, software-readable reset-cause register. Sits between the watchdog/trap logic and every other synchronous block in the design.

## Interface
- HOLD_CYCLES, 64: cycles both resets stay asserted after the last request drops; ≥1.
- STAGGER_CYCLES, 16: extra cycles the CPU reset stays asserted after the peripheral reset is released; ≥0.
- DEBOUNCE_BITS, 10: debounce counter width; used only with RESET_DEBOUNCE_EN.
- clk  in  1  system clock.
- reset_n  in  1  power-on reset; synchronous, active-low.
- wdt_reset  in  1  watchdog/trap reset request; level, active-high.
- ext_reset_n  in  1  external button; asynchronous, active-low.
- sw_reset  in  1  software reset request; single-cycle strobe.
- cause_write  in  1  write strobe for the cause register.
- cause_in  in  8  write data; write-1-to-clear.
- periph_reset  out  1  peripheral reset; active-high.
- cpu_reset  out  1  CPU reset; active-high.
- cause_out  out  8  reset-cause register.

## Operation
- Internal request is the OR of:
  - wdt_reset
  - sw_reset
  - the conditioned ext_reset_n request
- reset_n low overrides everything else.
- State machine:
  - HOLD: both outputs 1. Counter cleared while any request is active. Counter increments on each cycle with no request. When counter == HOLD_CYCLES-1, go to STAGGER, or go to RUN if STAGGER_CYCLES == 0. Counter clears on the transition.
  - STAGGER: periph_reset 0, cpu_reset 1. Counter increments each cycle. When counter == STAGGER_CYCLES-1, go to RUN.
  - RUN: both outputs 0.
- Any request in any state goes to HOLD with the counter at 0. A request in STAGGER reasserts periph_reset.
- Counter width is $clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1). The counter saturates and never wraps.
- Cause bits:
  - [0] power-on
  - [1] watchdog
  - [2] external
  - [3] software
  - [7:4] read as 0
- A cause bit is set on every cycle its source request is active.
- cause_write clears each bit where cause_in is 1.
- A set and a clear of the same bit in the same cycle: the set wins.
- Simultaneous requests set all of their bits.
- reset_n low: state HOLD, counter 0, periph_reset = 1, cpu_reset = 1, cause_out = 8'h01. Other cause bits are cleared. The ext_reset_n synchronizer and debounce are cleared.
- ext_reset_n always passes through a 2-flop synchronizer. The synchronizer is reset to the inactive level.

## Timing
- All outputs are registered.
- A request sampled at edge N gives periph_reset and cpu_reset = 1 after edge N.
- Exception: ext_reset_n adds 2 cycles of synchronizer latency.
- Let E be the first edge that samples no request.
  - periph_reset falls after edge E+HOLD_CYCLES-1.
  - cpu_reset falls STAGGER_CYCLES edges after periph_reset falls.
- cause_out updates one edge after the request or write.
- wdt_reset is expected to stay asserted for at least one cycle. A one-cycle pulse is sufficient.

## Configuration
- RESET_DEBOUNCE_EN defined:
  - The synchronized ext_reset_n must read 0 for 2^DEBOUNCE_BITS consecutive cycles before the external request asserts.
  - The request deasserts after the same number of consecutive 1 samples.
  - Any opposite sample restarts the count.
- RESET_DEBOUNCE_EN undefined:
  - The synchronized ext_reset_n level is the request directly.
  - DEBOUNCE_BITS is ignored.

## Structure
- Package reset_seq_pkg holds:
  - the state enum (HOLD, STAGGER, RUN)
  - cause bit index constants CAUSE_POR, CAUSE_WDT, CAUSE_EXT, CAUSE_SW
  - the cause register width
- Sub-module reset_debounce contains:
  - the 2-flop synchronizer
  - the optional debounce counter
  - output: a clean active-high ext request
- The top level holds the state machine, the counter and the cause register.

## Test plan
- Power-on with HOLD_CYCLES=4, STAGGER_CYCLES=2: reset_n low 3 cycles, then high.
  - Expect periph_reset to fall 4 cycles after release and cpu_reset 2 cycles later.
  - Expect cause_out = 8'h01.
- wdt_reset pulsed 1 cycle in RUN:
  - Both resets go to 1 on the next edge and the full HOLD/STAGGER sequence repeats.
  - Expect cause_out = 8'h03.
  - Write cause_in = 8'h02: expect cause_out = 8'h01.
- sw_reset strobe during STAGGER:
  - periph_reset reasserts, the counter restarts from 0 and bit 3 is set.
- sw_reset and cause_write with cause_in = 8'h08 in the same cycle:
  - bit 3 remains set.
- ext_reset_n low for 2 cycles then high:
  - with RESET_DEBOUNCE_EN: no reset and bit 2 clear.
  - without RESET_DEBOUNCE_EN: reset after 3 edges and bit 2 set.
- STAGGER_CYCLES=0:
  - cpu_reset and periph_reset fall on the same edge, and STAGGER is never entered.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states and
// reset-cause bit positions.
package reset_seq_pkg;

  localparam int CAUSE_W   = 8;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_EXT = 2;
  localparam int CAUSE_SW  = 3;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/reset_debounce.sv
// Conditions the asynchronous external reset button into a clean active-high
// request. Optional debounce filter enabled by defining RESET_DEBOUNCE_EN.
module reset_debounce #(
  parameter int DEBOUNCE_BITS = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ext_reset_n,
  output logic ext_req
);

  logic sync1_reg;
  logic sync2_reg;

  // Synchronizer parks at the button's inactive (high) level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= ext_reset_n;
      sync2_reg <= sync1_reg;
    end
  end

  if (DEBOUNCE_BITS < 1) begin : g_bad_cfg
    $error("DEBOUNCE_BITS must be at least 1");
  end

`ifdef RESET_DEBOUNCE_EN
  localparam logic [DEBOUNCE_BITS-1:0] DB_LAST = '1;

  logic [DEBOUNCE_BITS-1:0] db_cnt_reg;
  logic [DEBOUNCE_BITS-1:0] db_cnt_next;
  logic                     req_reg;
  logic                     req_next;

  // Count consecutive samples disagreeing with the current request; flip on
  // the 2^DEBOUNCE_BITS-th one, restart on any agreeing sample.
  always_comb begin
    db_cnt_next = '0;
    req_next    = req_reg;
    if ((~sync2_reg) != req_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        req_next = ~req_reg;
      end else begin
        db_cnt_next = db_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db_cnt_reg <= '0;
      req_reg    <= 1'b0;
    end else begin
      db_cnt_reg <= db_cnt_next;
      req_reg    <= req_next;
    end
  end

  assign ext_req = req_reg;
`else
  assign ext_req = ~sync2_reg;
`endif

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges reset requests, stretches and staggers the
// peripheral/CPU resets, keeps a sticky cause register. Debounce: RESET_DEBOUNCE_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES    = 64,
  parameter int STAGGER_CYCLES = 16,
  parameter int DEBOUNCE_BITS  = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wdt_reset,
  input  logic               ext_reset_n,
  input  logic               sw_reset,
  input  logic               cause_write,
  input  logic [CAUSE_W-1:0] cause_in,
  output logic               periph_reset,
  output logic               cpu_reset,
  output logic [CAUSE_W-1:0] cause_out
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   CNT_SAT      = '1;
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [CAUSE_W-1:0] CAUSE_MASK   = CAUSE_W'(8'h0F);

  if (HOLD_CYCLES < 1 || STAGGER_CYCLES < 0) begin : g_bad_cfg
    $error("HOLD_CYCLES must be >= 1 and STAGGER_CYCLES >= 0");
  end

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [CAUSE_W-1:0] cause_reg, cause_next, cause_set, cause_clr;
  logic               periph_reg, cpu_reg;
  logic               ext_req;
  logic               req;

  reset_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debounce (
    .clk        (clk),
    .reset_n    (reset_n),
    .ext_reset_n(ext_reset_n),
    .ext_req    (ext_req)
  );

  assign req = wdt_reset | sw_reset | ext_req;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cnt_inc    = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;
    if (req) begin
      state_next = HOLD;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            state_next = (STAGGER_CYCLES == 0) ? RUN : STAGGER;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        STAGGER: begin
          if (cnt_reg == STAGGER_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        RUN:     cnt_next = '0;
        default: begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // A source active in the same cycle as a clearing write keeps its bit set.
  always_comb begin
    cause_set            = '0;
    cause_set[CAUSE_WDT] = wdt_reset;
    cause_set[CAUSE_EXT] = ext_req;
    cause_set[CAUSE_SW]  = sw_reset;
    cause_clr            = cause_write ? cause_in : '0;
    cause_next           = ((cause_reg & ~cause_clr) | cause_set) & CAUSE_MASK;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg            <= HOLD;
      cnt_reg              <= '0;
      periph_reg           <= 1'b1;
      cpu_reg              <= 1'b1;
      cause_reg            <= '0;
      cause_reg[CAUSE_POR] <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      periph_reg <= (state_next == HOLD);
      cpu_reg    <= (state_next != RUN);
      cause_reg  <= cause_next;
    end
  end

  assign periph_reset = periph_reg;
  assign cpu_reset    = cpu_reg;
  assign cause_out    = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (with and without stagger) share
// stimulus; a quiet-cycle reference model feeds a scoreboard queue.
module tb_reset_sequencer;

  localparam int HOLD = 4;
  localparam int STAG = 2;
  localparam int DBB  = 3;

  logic       clk = 1'b0;
  logic       reset_n, wdt_reset, ext_reset_n, sw_reset, cause_write;
  logic [7:0] cause_in;
  logic       periph_a, cpu_a, periph_b, cpu_b;
  logic [7:0] cause_a, cause_b;

  always #5 clk = ~clk;

  reset_sequencer #(.HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .DEBOUNCE_BITS(DBB)) dut_a (
    .clk(clk), .reset_n(reset_n), .wdt_reset(wdt_reset), .ext_reset_n(ext_reset_n),
    .sw_reset(sw_reset), .cause_write(cause_write), .cause_in(cause_in),
    .periph_reset(periph_a), .cpu_reset(cpu_a), .cause_out(cause_a)
  );

  reset_sequencer #(.HOLD_CYCLES(HOLD), .STAGGER_CYCLES(0), .DEBOUNCE_BITS(DBB)) dut_b (
    .clk(clk), .reset_n(reset_n), .wdt_reset(wdt_reset), .ext_reset_n(ext_reset_n),
    .sw_reset(sw_reset), .cause_write(cause_write), .cause_in(cause_in),
    .periph_reset(periph_b), .cpu_reset(cpu_b), .cause_out(cause_b)
  );

  typedef struct packed {
    logic       pa;
    logic       ca;
    logic       pb;
    logic       cb;
    logic [7:0] cause;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   stim_done = 1'b0;

  // Reference model: resets are a function of how many consecutive
  // request-free edges have elapsed since the last request or power-on.
  int         quiet = 0;
  logic [7:0] cause_m = 8'h00;
  logic       s1_m = 1'b1, s2_m = 1'b1, ext_req_m = 1'b0;
  int         db_run = 0;

  task automatic model_edge();
    logic       req;
    logic [7:0] set_m;
    exp_t       e;
    if (!reset_n) begin
      quiet     = 0;
      cause_m   = 8'h01;
      s1_m      = 1'b1;
      s2_m      = 1'b1;
      ext_req_m = 1'b0;
      db_run    = 0;
    end else begin
      req   = wdt_reset | sw_reset | ext_req_m;
      quiet = req ? 0 : ((quiet < 1000) ? quiet + 1 : quiet);
      set_m = {4'h0, sw_reset, ext_req_m, wdt_reset, 1'b0};
      if (cause_write) cause_m = cause_m & ~cause_in;
      cause_m = (cause_m | set_m) & 8'h0F;
`ifdef RESET_DEBOUNCE_EN
      if ((!s2_m) != ext_req_m) begin
        db_run++;
        if (db_run == (1 << DBB)) begin
          ext_req_m = !ext_req_m;
          db_run    = 0;
        end
      end else begin
        db_run = 0;
      end
`endif
      s2_m = s1_m;
      s1_m = ext_reset_n;
`ifndef RESET_DEBOUNCE_EN
      ext_req_m = !s2_m;
`endif
    end
    e.pa    = (quiet < HOLD);
    e.ca    = (quiet < HOLD + STAG);
    e.pb    = (quiet < HOLD);
    e.cb    = (quiet < HOLD);
    e.cause = cause_m;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rn, input logic wd, input logic en, input logic sw,
                      input logic cw, input logic [7:0] ci);
    reset_n     = rn;
    wdt_reset   = wd;
    ext_reset_n = en;
    sw_reset    = sw;
    cause_write = cw;
    cause_in    = ci;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", nm, cyc, act, want);
    end
  endtask

  // Monitor: every edge presents a new output set; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("periph_a", {7'd0, periph_a}, {7'd0, e.pa});
        cmp("cpu_a",    {7'd0, cpu_a},    {7'd0, e.ca});
        cmp("periph_b", {7'd0, periph_b}, {7'd0, e.pb});
        cmp("cpu_b",    {7'd0, cpu_b},    {7'd0, e.cb});
        cmp("cause_a",  cause_a, e.cause);
        cmp("cause_b",  cause_b, e.cause);
        $display("cyc %0d rst_n=%b wdt=%b ext_n=%b sw=%b cw=%b ci=%h | a:%b%b b:%b%b cause=%h",
                 cyc, reset_n, wdt_reset, ext_reset_n, sw_reset, cause_write, cause_in,
                 periph_a, cpu_a, periph_b, cpu_b, cause_a);
      end
    end
  end

  initial begin
    int ext_low_left;
    logic rn, wd, sw, cw;
    logic [7:0] ci;
    reset_n = 1'b0; wdt_reset = 1'b0; ext_reset_n = 1'b1;
    sw_reset = 1'b0; cause_write = 1'b0; cause_in = 8'h00;
    @(negedge clk);

    // Power-on
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(10);
    // Watchdog pulse in RUN, then clear its cause bit
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(10);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02);
    idle(2);
    // Software strobe while instance A is in STAGGER
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(5);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    idle(10);
    // Set and clear of the software bit in the same cycle
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h08);
    idle(10);
    // Short external button press
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(12);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
    idle(3);

    ext_low_left = 0;
    repeat (1500) begin
      rn = ($urandom_range(0, 299) != 0);
      wd = ($urandom_range(0, 39) == 0);
      sw = ($urandom_range(0, 39) == 0);
      cw = ($urandom_range(0, 7) == 0);
      ci = 8'($urandom);
      if (ext_low_left == 0 && $urandom_range(0, 59) == 0)
        ext_low_left = $urandom_range(1, 12);
      step(rn, wd, (ext_low_left == 0), sw, cw, ci);
      if (ext_low_left > 0) ext_low_left--;
    end
    idle(12);
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
